// File: rtl/team_06_delay_pkg.sv
// Shared types and constants for the circular delay-line controller.
package team_06_delay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_DEPTH = 8192;
  localparam int unsigned PTR_W         = $clog2(DEFAULT_DEPTH);
  localparam int unsigned OFFSET_W      = 13;
  localparam int unsigned SAMPLE_W      = 8;

  // Pointer width for a given buffer depth; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/team_06_delay_ptr.sv
// Write pointer and saturating fill counter for the circular buffer.
module team_06_delay_ptr
  import team_06_delay_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] fill
);

  localparam logic [PW-1:0] FILL_MAX = PW'(DEPTH - 1);

  // Pointer wraps naturally at the power-of-two depth; fill stops at DEPTH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (advance) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (fill != FILL_MAX) fill <= fill + PW'(1);
    end
  end

endmodule

// File: rtl/team_06_delay_buffer_ctrl.sv
// Circular delay-line controller: stores each sample to SRAM and optionally
// reads back the sample written `offset` positions earlier.
module team_06_delay_buffer_ctrl
  import team_06_delay_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] save_audio,
  input  logic                search,
  input  logic [OFFSET_W-1:0] offset,
  output logic [SAMPLE_W-1:0] past_output,
  output logic                past_valid,
  output logic                search_enable,
  output logic                busy,
  output logic                overrun,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [SAMPLE_W-1:0] mem_wdata,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  input  logic                mem_ack
);

  localparam int unsigned PW = ptr_width(DEPTH);

  state_e              state, state_d;
  logic [PW-1:0]       wr_ptr, fill;
  logic [PW-1:0]       wr_addr, wr_addr_d;
  logic [PW-1:0]       rd_addr, rd_addr_d;
  logic [PW-1:0]       off_lo;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                do_read, do_read_d;
  logic                advance;
  logic [SAMPLE_W-1:0] past_output_d;
  logic                past_valid_d;
  logic                overrun_d;
  logic                search_enable_d;

  assign off_lo = offset[PW-1:0];

  // Offsets at or beyond DEPTH can never be satisfied.
  assign search_enable_d = (offset != '0) && (32'(offset) < DEPTH) &&
                           (OFFSET_W'(fill) >= offset);

  team_06_delay_ptr #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .wr_ptr  (wr_ptr),
    .fill    (fill)
  );

  // Next-state, transaction context and result decode.
  always_comb begin
    state_d       = state;
    wr_addr_d     = wr_addr;
    rd_addr_d     = rd_addr;
    sample_d      = sample_q;
    do_read_d     = do_read;
    past_output_d = past_output;
    past_valid_d  = 1'b0;
    overrun_d     = overrun;
    advance       = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          sample_d  = save_audio;
          wr_addr_d = wr_ptr;
          rd_addr_d = wr_ptr - off_lo;
          do_read_d = search & search_enable;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (sample_valid) overrun_d = 1'b1;
        if (mem_ack) begin
          advance = 1'b1;
          state_d = do_read ? READ : IDLE;
        end
      end
      READ: begin
        if (sample_valid) overrun_d = 1'b1;
        if (mem_ack) begin
          past_output_d = mem_rdata;
          past_valid_d  = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured transaction context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_addr  <= '0;
      rd_addr  <= '0;
      sample_q <= '0;
      do_read  <= 1'b0;
    end else begin
      state    <= state_d;
      wr_addr  <= wr_addr_d;
      rd_addr  <= rd_addr_d;
      sample_q <= sample_d;
      do_read  <= do_read_d;
    end
  end

  // Bus drive is registered from the next state so mem_req stays high
  // across WRITE->READ while mem_we/mem_addr switch in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      past_output   <= '0;
      past_valid    <= 1'b0;
      search_enable <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      past_output   <= past_output_d;
      past_valid    <= past_valid_d;
      search_enable <= search_enable_d;
      busy          <= (state_d != IDLE);
      overrun       <= overrun_d;
      mem_req       <= (state_d != IDLE);
      mem_we        <= (state_d == WRITE);
      mem_addr      <= (state_d == WRITE) ? BASE_ADDR + 32'(wr_addr_d) :
                       (state_d == READ)  ? BASE_ADDR + 32'(rd_addr_d) : '0;
      mem_wdata     <= (state_d == WRITE) ? sample_d : '0;
    end
  end

endmodule

// File: tb/tb_team_06_delay_buffer_ctrl.sv
// Self-checking bench for team_06_delay_buffer_ctrl (DEPTH=16, nonzero base).
module tb_team_06_delay_buffer_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  save_audio = '0;
  logic        search = 1'b0;
  logic [12:0] offset = '0;
  logic [7:0]  past_output;
  logic        past_valid, search_enable, busy, overrun;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  team_06_delay_buffer_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .save_audio(save_audio),
    .search(search), .offset(offset), .past_output(past_output),
    .past_valid(past_valid), .search_enable(search_enable), .busy(busy),
    .overrun(overrun), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  data;
  } txn_t;

  typedef struct {
    logic [7:0]  s;
    logic        srch;
    logic [12:0] off;
    bit          en;
    int          ws;
    bit          rd;
    int          rs;
    logic [7:0]  past;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         pv_count = 0;
  int         req_gap = 0;
  int         ack_delay = 1;
  bit         hold_reads = 1'b0;
  txn_t       txq[$];
  logic [7:0] hist[$];
  logic [7:0] last_past = '0;
  logic [7:0] tb_mem[DEPTH];
  vec_t       tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // SRAM responder: acks after ack_delay request cycles, one-cycle pulse.
  initial begin
    int wcnt;
    int idx;
    mem_ack = 1'b0;
    mem_rdata = '0;
    wcnt = 0;
    foreach (tb_mem[i]) tb_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (rst || !mem_req) begin
        wcnt = 0;
      end else if (hold_reads && !mem_we) begin
        wcnt = 0;
      end else if (wcnt >= ack_delay) begin
        idx = int'(mem_addr - BASE) & int'(DEPTH - 1);
        mem_ack = 1'b1;
        if (mem_we) tb_mem[idx] = mem_wdata;
        else mem_rdata = tb_mem[idx];
        txq.push_back('{we: mem_we, addr: mem_addr, data: mem_we ? mem_wdata : tb_mem[idx]});
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  // Observe pulses and any request gap while busy.
  always @(negedge clk) begin
    if (past_valid) pv_count++;
    if (busy && !mem_req) req_gap++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_valid = 1'b0; search = 1'b0; offset = '0; hold_reads = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hist.delete();
    last_past = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("idle_within_bound", 32'(busy), 32'd0);
  endtask

  task automatic run_sample(input logic [7:0] s, input logic srch, input logic [12:0] off,
                            input bit inj, input bit e_en, input int e_ws, input bit e_rd,
                            input int e_rs, input logic [7:0] e_past);
    int pv0;
    int gap0;
    @(negedge clk);
    search = srch; offset = off;
    repeat (2) @(negedge clk);
    chk("search_enable", 32'(search_enable), 32'(e_en));
    txq.delete();
    pv0 = pv_count; gap0 = req_gap;
    save_audio = s; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    if (inj) begin
      for (int i = 0; i < 50 && !(mem_req && !mem_we); i++) @(negedge clk);
      chk("reach_read_for_overrun", 32'(mem_req && !mem_we), 32'd1);
      save_audio = 8'hEE; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
    end
    wait_idle();
    @(negedge clk);
    chk("txn_count", 32'(txq.size()), e_rd ? 32'd2 : 32'd1);
    if (txq.size() >= 1) begin
      chk("wr_we", 32'(txq[0].we), 32'd1);
      chk("wr_addr", txq[0].addr, BASE + 32'(e_ws));
      chk("wr_data", 32'(txq[0].data), 32'(s));
    end
    if (e_rd && txq.size() >= 2) begin
      chk("rd_we", 32'(txq[1].we), 32'd0);
      chk("rd_addr", txq[1].addr, BASE + 32'(e_rs));
    end
    chk("past_valid_pulses", 32'(pv_count - pv0), e_rd ? 32'd1 : 32'd0);
    chk("past_output", 32'(past_output), 32'(e_past));
    chk("req_held_while_busy", 32'(req_gap - gap0), 32'd0);
    hist.push_back(s);
    last_past = e_past;
  endtask

  // Reference: history as a list of accepted samples, expectations by count.
  task automatic model_sample(input logic [7:0] s, input logic srch, input logic [12:0] off,
                              input bit inj);
    int n, fillm, o, rs;
    bit en, rd;
    logic [7:0] p;
    n = hist.size();
    fillm = (n < int'(DEPTH) - 1) ? n : int'(DEPTH) - 1;
    o = int'(off);
    en = (o != 0) && (o < int'(DEPTH)) && (o <= fillm);
    rd = srch && en;
    rs = rd ? (n - o) % int'(DEPTH) : 0;
    p = rd ? hist[n - o] : last_past;
    run_sample(s, srch, off, inj, en, n % int'(DEPTH), rd, rs, p);
  endtask

  initial begin
    // Vectors: ten writes with offset 4 (no search), then history reads at offset 3.
    for (int k = 0; k < 10; k++)
      tbl[k] = '{s: 8'(k + 1), srch: 1'b0, off: 13'd4, en: (k >= 4), ws: k,
                 rd: 1'b0, rs: 0, past: 8'h00};
    for (int k = 0; k < 8; k++)
      tbl[10 + k] = '{s: 8'(8'h10 + k), srch: 1'b1, off: 13'd3, en: (k >= 3), ws: k,
                      rd: (k >= 3), rs: (k >= 3) ? k - 3 : 0,
                      past: (k >= 3) ? 8'(8'h10 + k - 3) : 8'h00};

    do_reset();
    chk("rst_past_output", 32'(past_output), 32'd0);
    chk("rst_past_valid", 32'(past_valid), 32'd0);
    chk("rst_search_enable", 32'(search_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

    for (int i = 0; i < 18; i++) begin
      if (i == 10) do_reset();
      run_sample(tbl[i].s, tbl[i].srch, tbl[i].off, 1'b0, tbl[i].en, tbl[i].ws,
                 tbl[i].rd, tbl[i].rs, tbl[i].past);
      if (i == 15) chk("hist_read_slot5_past", 32'(past_output), 32'h12);
    end

    // Wrap: 20th sample lands in slot 3, offset 5 reads slot 14 (sample 15).
    do_reset();
    for (int k = 0; k < 19; k++) model_sample(8'(k + 1), 1'b0, 13'd0, 1'b0);
    model_sample(8'd20, 1'b1, 13'd5, 1'b0);
    chk("wrap_write_addr", (txq.size() > 0) ? txq[0].addr : 32'hFFFF_FFFF, BASE + 32'd3);
    chk("wrap_read_addr", (txq.size() > 1) ? txq[1].addr : 32'hFFFF_FFFF, BASE + 32'd14);
    chk("wrap_past", 32'(past_output), 32'd15);

    // Offset edges: zero and beyond depth never enable a read.
    model_sample(8'h31, 1'b1, 13'd0, 1'b0);
    chk("off0_no_read", 32'(txq.size()), 32'd1);
    model_sample(8'h32, 1'b1, 13'd20, 1'b0);
    chk("off20_no_enable", 32'(search_enable), 32'd0);
    model_sample(8'h33, 1'b1, 13'd16, 1'b0);

    // Randomized traffic with variable SRAM latency.
    for (int r = 0; r < 120; r++) begin
      ack_delay = int'($urandom_range(0, 3));
      model_sample(8'($urandom), 1'($urandom), 13'($urandom_range(0, 20)), 1'b0);
    end

    // Overrun: sample during a slow read is dropped; flag sticks.
    chk("overrun_clear_before", 32'(overrun), 32'd0);
    ack_delay = 4;
    model_sample(8'hA5, 1'b1, 13'd2, 1'b1);
    chk("overrun_set", 32'(overrun), 32'd1);
    ack_delay = 1;
    model_sample(8'hA6, 1'b0, 13'd2, 1'b0);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset while the read ack is withheld.
    begin
      int pv0;
      @(negedge clk);
      search = 1'b1; offset = 13'd1;
      repeat (2) @(negedge clk);
      hold_reads = 1'b1;
      pv0 = pv_count;
      save_audio = 8'h5A; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      for (int i = 0; i < 50 && !(mem_req && !mem_we); i++) @(negedge clk);
      chk("midrd_reach_read", 32'(mem_req && !mem_we), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrd_mem_req", 32'(mem_req), 32'd0);
      chk("midrd_busy", 32'(busy), 32'd0);
      chk("midrd_overrun", 32'(overrun), 32'd0);
      chk("midrd_past_output", 32'(past_output), 32'd0);
      hold_reads = 1'b0;
      search = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrd_no_past_valid", 32'(pv_count - pv0), 32'd0);
      hist.delete();
      last_past = '0;
      model_sample(8'h77, 1'b0, 13'd1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
